// File: rtl/rv32_pkg.sv
// RV32I load/store encodings and LSU state encoding shared by the
// load_store_unit top and its lane-alignment helper.
package rv32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU.
// Load path: pick the byte/halfword lane from a memory word and extend it.
// Store path: merge store data into the old word at the addressed lane.
// Halfword lanes use only off[1]; word accesses ignore off entirely.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]         byte_sh;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  assign byte_sh = {off, 3'b000};

  // Load lane extraction with sign or zero extension
  always_comb begin
    lane_b    = $signed(word[byte_sh +: 8]);
    lane_h    = off[1] ? $signed(word[31:16]) : $signed(word[15:0]);
    load_data = word;
    case (funct3)
      F3_B:    load_data = 32'(lane_b);
      F3_BU:   load_data = {24'd0, lane_b};
      F3_H:    load_data = 32'(lane_h);
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = word;
    endcase
  end

  // Store lane merge into the previously read word
  always_comb begin
    store_word = word;
    case (funct3)
      F3_B: store_word[byte_sh +: 8] = wdata[7:0];
      F3_H: begin
        if (off[1]) store_word[31:16] = wdata[15:0];
        else        store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a word-wide, single-write-enable data memory.
// Sub-word stores are done as read-modify-write (READ then WRITE).
// Optional build macro MISALIGN_TRAP_EN: misaligned H/HU/W accesses fault;
// when undefined the offending low address bits are simply ignored.
module load_store_unit
  import rv32_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_we
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  lsu_state_t  state, state_nx;
  logic        accept;
  logic        illegal, out_of_range, misaligned, req_fault;
  logic        rq_we;
  logic [2:0]  rq_funct3;
  logic [31:0] rq_addr, rq_wdata;
  logic [31:0] ld_data, st_word;

  assign accept = req_valid && req_ready;

  // Request checks evaluated on the incoming request before acceptance
  always_comb begin
    if (req_we) illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
    else        illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);
    misaligned   = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misaligned = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                 ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`endif
    req_fault = illegal || out_of_range || misaligned;
  end

  lsu_align u_align (
    .word       (mem_rdata),
    .wdata      (rq_wdata),
    .off        (rq_addr[1:0]),
    .funct3     (rq_funct3),
    .load_data  (ld_data),
    .store_word (st_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_fault)                          state_nx = RESP;
          else if (req_we && req_funct3 == F3_W)  state_nx = WRITE;
          else                                    state_nx = READ;
        end
      end
      READ:    state_nx = rq_we ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded outputs; the write strobe is suppressed while in reset
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_we     = (state == WRITE) && !rst;
  end

  // Request latch, loaded on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      rq_we     <= req_we;
      rq_funct3 <= req_funct3;
      rq_addr   <= req_addr;
      rq_wdata  <= req_wdata;
    end
  end

  // Memory address/data and response registers; addresses hold between uses
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_raddr  <= '0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            resp_rdata <= '0;
            resp_fault <= req_fault;
            if (!req_fault) begin
              if (req_we && req_funct3 == F3_W) begin
                mem_waddr <= {req_addr[31:2], 2'b00};
                mem_wdata <= req_wdata;
              end else begin
                mem_raddr <= {req_addr[31:2], 2'b00};
              end
            end
          end
        end
        READ: begin
          if (rq_we) begin
            mem_waddr <= {rq_addr[31:2], 2'b00};
            mem_wdata <= st_word;
          end else begin
            resp_rdata <= ld_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a behavioural data memory, a byte-level
// reference model, and a response scoreboard checked by a separate monitor.
module tb_load_store_unit;

  localparam int MEM_WORDS = 1024;

  typedef struct {
    bit          fault;
    bit [31:0]   rdata;
    int          lat;
    int          acc;
    bit          wr;
    bit [31:0]   waddr;
    bit [31:0]   wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic        mem_we;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_seen = 0;
  exp_t cur_exp;
  exp_t q[$];

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we)
  );

  // data_memory: combinational read, write on rising edge
  assign mem_rdata = mem[mem_raddr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_waddr[11:2]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[a[11:2]];
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  function automatic void wr_byte(input logic [31:0] a, input logic [7:0] b);
    logic [31:0] w;
    w = ref_mem[a[11:2]];
    w[{a[1:0], 3'b000} +: 8] = b;
    ref_mem[a[11:2]] = w;
  endfunction

  // Reference model: byte-addressed little-endian memory with RV32I rules
  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output exp_t e);
    int n;
    bit legal, sgn;
    longint v;
    logic [31:0] ea, rem;
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      default:    n = 4;
    endcase
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sgn   = (f3 == 3'd0 || f3 == 3'd1);
    rem   = addr % 32'(n);
    e.fault = !legal || (addr >= 32'(MEM_WORDS * 4));
`ifdef MISALIGN_TRAP_EN
    if (rem != 0) e.fault = 1'b1;
`endif
    ea = addr - rem;
    e.rdata = 0; e.wr = 0; e.waddr = 0; e.wdata = 0; e.lat = 0; e.acc = 0;
    if (e.fault) return;
    if (!we) begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(rd_byte(ea + 32'(i))) << (8 * i);
      if (n < 4 && sgn && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
      e.rdata = v[31:0];
      e.lat   = 1;
    end else begin
      for (int i = 0; i < n; i++) wr_byte(ea + 32'(i), 8'(wd >> (8 * i)));
      e.wr    = 1;
      e.waddr = {ea[31:2], 2'b00};
      e.wdata = ref_mem[ea[11:2]];
      e.lat   = (n == 4) ? 1 : 2;
    end
  endfunction

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    wait_ready();
    model(we, f3, addr, wd, e);
    e.acc   = cyc + 1;
    cur_exp = e;
    wr_seen = 0;
    q.push_back(e);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Monitor: write-port checks and response scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        check("unexpected_we", {31'd0, cur_exp.wr}, 32'd1);
        check("mem_waddr", mem_waddr, cur_exp.waddr);
        check("mem_wdata", mem_wdata, cur_exp.wdata);
        wr_seen++;
      end
      if (resp_valid === 1'b1) begin
        if (q.size() == 0) begin
          check("spurious_resp", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
          check("write_count", 32'(wr_seen), {31'd0, e.wr});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic        we;
    int          k;
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem[1] = 32'h0000_0001; ref_mem[1] = 32'h0000_0001;
    mem[2] = 32'h0000_0010; ref_mem[2] = 32'h0000_0010;
    cur_exp = '{default: 0};
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we",     {31'd0, mem_we},     32'd0);
    check("rst_mem_raddr",  mem_raddr, 32'd0);
    check("rst_mem_waddr",  mem_waddr, 32'd0);
    check("rst_mem_wdata",  mem_wdata, 32'd0);
    rst = 1'b0;

    // Directed loads and stores on preloaded memory
    issue(1'b0, 3'b010, 32'h8, 32'd0);
    issue(1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF);
    issue(1'b0, 3'b010, 32'h0, 32'd0);
    issue(1'b0, 3'b000, 32'h3, 32'd0);
    issue(1'b0, 3'b100, 32'h3, 32'd0);
    issue(1'b0, 3'b001, 32'h2, 32'd0);
    issue(1'b1, 3'b000, 32'h5, 32'h0000_00AB);
    issue(1'b0, 3'b010, 32'h4, 32'd0);
    issue(1'b0, 3'b010, 32'h6, 32'd0);
    issue(1'b0, 3'b010, 32'h1000, 32'd0);
    issue(1'b1, 3'b010, 32'h1000, 32'h1111_1111);
    issue(1'b1, 3'b100, 32'h0, 32'h2222_2222);
    issue(1'b0, 3'b011, 32'h0, 32'd0);
    issue(1'b0, 3'b101, 32'h7, 32'd0);

    // SH aborted by reset during its WRITE cycle: no write, back to idle
    wait_ready();
    cur_exp = '{default: 0};
    wr_seen = 0;
    req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h0; req_wdata = 32'h0000_1234;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("abort_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    issue(1'b0, 3'b010, 32'h0, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      k  = int'($urandom_range(0, 99));
      we = 1'($urandom_range(0, 1));
      if (k < 88)      a = 32'($urandom_range(0, 63));
      else if (k < 95) a = 32'h1000 + 32'($urandom_range(0, 255));
      else             a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      issue(we, 3'($urandom_range(0, 7)), a, $urandom);
    end

    // Drain outstanding responses
    k = 0;
    while (q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("drain_queue", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
